// File: rtl/fifo_arb_pkg.sv
// Purpose    : shared types and default sizes for the fifo_sync write-port arbiter.
// Latency    : n/a (declarations only).
// Backpressure: n/a.
// Contents   : arb_state_t (IDLE/BURST) and default NUM_REQ, DATA_W, BURST_MAX, CNT_W.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,   // no producer owns the FIFO write port
        BURST = 1'b1    // grant_id owns the port until release
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_MAX = 4;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Purpose    : round-robin priority search; first set req_valid at rr_ptr, rr_ptr+1, ... mod NUM_REQ.
// Latency    : purely combinational.
// Backpressure: none; pick is recomputed every cycle.
// Ports      : req_valid[NUM_REQ], rr_ptr[IDX_W] in; pick_valid, pick_idx[IDX_W] out.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               pick_valid,
    output logic [IDX_W-1:0]   pick_idx
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest valid one wins
    // last; the wrap is explicit so non-power-of-two NUM_REQ works.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Purpose    : shares the fifo_sync write port among NUM_REQ producers, round-robin with bounded bursts.
// Latency    : grant registered one cycle after req_valid in IDLE; beats then pass combinationally to the FIFO.
// Backpressure: fifo_full combinationally clears req_ready and fifo_wr_en; owner keeps its grant while stalled.
// Ports      : clk, rst_n (async, active-low); req_valid/req_data/req_ready per producer;
//              fifo_full in, fifo_wr_en/fifo_data_in out; grant_valid/grant_id status;
//              grant_cnt/stall_cnt statistics, live only when FIFO_ARB_STATS_EN is defined (else tied 0).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_data_in,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_REQ*CNT_W-1:0]   grant_cnt,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(BURST_MAX + 1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [BEAT_W-1:0]  beat_cnt;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_vld;
    logic [DATA_W-1:0]  owner_dat;
    logic               accept;
    logic               release_now;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_valid  (req_valid),
        .rr_ptr     (rr_ptr),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    // Owner's request and data, selected by grant_id.
    always_comb begin
        owner_vld = 1'b0;
        owner_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
                owner_vld = req_valid[i];
                owner_dat = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept      = (state == BURST) && owner_vld && !fifo_full;
    // Release when the owner goes idle or its BURST_MAX-th beat is accepted.
    assign release_now = (state == BURST) &&
                         (!owner_vld || (accept && (beat_cnt == BEAT_W'(BURST_MAX - 1))));

    // State register plus the grant bookkeeping that moves with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_valid) begin
                grant_id <= pick_idx;
                beat_cnt <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            // Released owner drops to lowest priority next arbitration.
            if (release_now) begin
                rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid)  state_nxt = BURST;
            BURST:   if (release_now) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: fifo_full feeds req_ready/fifo_wr_en directly so the FIFO
    // never sees a write while full.
    always_comb begin
        grant_valid  = 1'b0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        if (state == BURST) begin
            grant_valid  = 1'b1;
            fifo_wr_en   = accept;
            fifo_data_in = owner_dat;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (grant_id == IDX_W'(i)) && !fifo_full;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] gcnt [NUM_REQ];
    logic [CNT_W-1:0] stall_q;

    // Saturating counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gcnt[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && grant_id == IDX_W'(i) && gcnt[i] != CNT_MAX) begin
                    gcnt[i] <= gcnt[i] + 1'b1;
                end
            end
            if (state == BURST && owner_vld && fifo_full && stall_q != CNT_MAX) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = gcnt[i];
        end
    end

    assign stall_cnt = stall_q;
`else
    assign grant_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose    : self-checking bench for fifo_wr_arbiter; cycle reference model feeds a scoreboard.
// Latency    : n/a.
// Backpressure: fifo_full driven directly by the bench (directed and random).
module tb_fifo_wr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int BM   = 4;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;
`ifdef FIFO_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              fifo_full = 1'b0;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data_in;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic [N*CW-1:0]   grant_cnt;
    logic [CW-1:0]     stall_cnt;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(BM), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .grant_cnt    (grant_cnt),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [7:0] data;
        logic [3:0] ready;
        logic       gv;
        logic [1:0] gid;
    } exp_t;

    exp_t       ctrl_q[$];
    logic [7:0] wq[$];
    int         n_chk = 0;
    int         n_pass = 0;

    // Producer side
    int         pq[N][$];
    bit         vld[N];
    bit         want[N];
    logic [7:0] drv[N];
    bit         full_nxt = 1'b0;

    // Reference model: owner < 0 means nobody holds the port.
    int owner = -1;
    int ptr = 0;
    int beats = 0;
    int m_gc[N];
    int m_stall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic int ev(input int v);
        return STATS ? v : 0;
    endfunction

    task automatic model_reset();
        owner = -1; ptr = 0; beats = 0; m_stall = 0;
        for (int i = 0; i < N; i++) m_gc[i] = 0;
    endtask

    // Drive one cycle of stimulus (at posedge+1), predict the cycle's
    // outputs and advance the model to the post-edge state.
    task automatic body();
        exp_t e;
        int   c;
        bit   ov;
        for (int i = 0; i < N; i++) begin
            if (!vld[i] && want[i] && pq[i].size() > 0) vld[i] = 1'b1;
            drv[i] = vld[i] ? 8'(pq[i][0]) : 8'($urandom);
            req_valid[i] = vld[i];
            req_data[i*DW +: DW] = drv[i];
        end
        fifo_full = full_nxt;
        e = '0;
        ov = 1'b0;
        c = owner;
        if (c >= 0) begin
            ov     = vld[c];
            e.gv   = 1'b1;
            e.gid  = 2'(c);
            e.ready = full_nxt ? 4'b0 : (4'b1 << c);
            e.wr   = ov && !full_nxt;
            e.data = drv[c];
        end
        ctrl_q.push_back(e);
        if (e.wr) wq.push_back(e.data);
        if (c < 0) begin
            for (int k = 0; k < N; k++) begin
                if (vld[(ptr + k) % N]) begin
                    owner = (ptr + k) % N;
                    beats = 0;
                    break;
                end
            end
        end else begin
            if (e.wr) begin
                beats++;
                if (m_gc[c] < CMAX) m_gc[c]++;
                void'(pq[c].pop_front());
                vld[c] = 1'b0;
            end
            if (ov && full_nxt && m_stall < CMAX) m_stall++;
            if (!ov || beats == BM) begin
                ptr = (c + 1) % N;
                owner = -1;
            end
        end
    endtask

    task automatic cyc(input bit f);
        @(posedge clk); #1;
        full_nxt = f;
        body();
    endtask

    task automatic check_counters(input string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_gcnt%0d", tag, i), 64'(grant_cnt[i*CW +: CW]), 64'(ev(m_gc[i])));
        chk({tag, "_stall"}, 64'(stall_cnt), 64'(ev(m_stall)));
    endtask

    // Assert reset away from the edge, check outputs in the same cycle,
    // release it a cycle later and continue with stimulus immediately.
    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_rst_wr_en"}, 64'(fifo_wr_en), 64'(0));
        chk({tag, "_rst_gvalid"}, 64'(grant_valid), 64'(0));
        chk({tag, "_rst_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rst_data"}, 64'(fifo_data_in), 64'(0));
        chk({tag, "_rst_gcnt"}, 64'(grant_cnt), 64'(0));
        chk({tag, "_rst_stall"}, 64'(stall_cnt), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        full_nxt = 1'b0;
        body();
    endtask

    task automatic drain(input string tag);
        int  n;
        bit  busy;
        n = 0;
        for (int i = 0; i < N; i++) want[i] = 1'b1;
        do begin
            busy = (owner >= 0);
            for (int i = 0; i < N; i++) if (pq[i].size() > 0) busy = 1'b1;
            if (busy) begin
                cyc(1'b0);
                n++;
            end
        end while (busy && n < 600);
        if (busy) begin
            n_chk++;
            $display("FAIL %s_drain_timeout: still busy after %0d cycles, expected idle", tag, n);
        end
    endtask

    task automatic set_want(input bit w0, input bit w1, input bit w2, input bit w3);
        want[0] = w0; want[1] = w1; want[2] = w2; want[3] = w3;
    endtask

    // Monitor: per-cycle control check, and write-data pops whenever the DUT writes.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ctrl_q.size() == 0) begin
                n_chk++;
                $display("FAIL ctrl_underflow: got empty queue, expected an entry");
            end else begin
                e = ctrl_q.pop_front();
                chk("wr_en", 64'(fifo_wr_en), 64'(e.wr));
                chk("req_ready", 64'(req_ready), 64'(e.ready));
                chk("grant_valid", 64'(grant_valid), 64'(e.gv));
                chk("data_in", 64'(fifo_data_in), e.gv ? 64'(e.data) : 64'(0));
                if (e.gv) chk("grant_id", 64'(grant_id), 64'(e.gid));
            end
            if (fifo_wr_en) begin
                if (wq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: got data %0h, expected no write", fifo_data_in);
                end else begin
                    chk("write_data", 64'(fifo_data_in), 64'(wq.pop_front()));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin vld[i] = 1'b0; want[i] = 1'b0; m_gc[i] = 0; end

        // Single producer 2 streaming six beats.
        pq[2] = '{56, 7, 41, 5, 12, 6};
        set_want(0, 0, 1, 0);
        do_reset("init");
        drain("single");
        @(posedge clk); #1;
        chk("single_gcnt2", 64'(grant_cnt[2*CW +: CW]), 64'(ev(6)));
        check_counters("single");
        body();

        // All four valid from reset: 0,1,2,3,0... with 4-beat bursts.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 8; j++) pq[i].push_back($urandom_range(0, 255));
        set_want(1, 1, 1, 1);
        do_reset("all4");
        drain("all4");
        @(posedge clk); #1;
        check_counters("all4");
        body();

        // Owner 1 stalled by full for 5 cycles after 2 beats.
        for (int j = 0; j < 4; j++) pq[1].push_back($urandom_range(0, 255));
        set_want(0, 1, 0, 0);
        do_reset("stall");
        for (int k = 1; k <= 12; k++) cyc(k >= 3 && k <= 7);
        @(posedge clk); #1;
        chk("stall_cnt5", 64'(stall_cnt), 64'(ev(5)));
        chk("stall_gcnt1", 64'(grant_cnt[1*CW +: CW]), 64'(ev(4)));
        body();

        // Owner 0 drops after one beat while 3 waits.
        pq[0].push_back(8'h3c);
        pq[3].push_back(8'ha5);
        pq[3].push_back(8'h5a);
        set_want(1, 0, 0, 1);
        do_reset("drop");
        drain("drop");

        // Reset in the middle of a burst.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 6; j++) pq[i].push_back($urandom_range(0, 255));
        set_want(1, 1, 1, 1);
        for (int k = 0; k < 3; k++) cyc(1'b0);
        do_reset("midrst");
        drain("midrst");

        // Random traffic with random full; long enough to saturate counters.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i]) want[i] = ($urandom_range(0, 3) != 0);
                if (pq[i].size() < 2) pq[i].push_back($urandom_range(0, 255));
            end
            cyc($urandom_range(0, 4) == 0);
        end
        drain("rand");
        @(posedge clk); #1;
        check_counters("final");
        chk("wq_empty", 64'(wq.size()), 64'(0));
        body();
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Shares the single write port of the `fifo_sync` 8-bit FIFO between NUM_REQ producers.
- Uses round-robin arbitration with bounded bursts, so one producer cannot starve the others.
- Honours the FIFO's `full` flag.
- Sits directly in front of the FIFO: its `fifo_wr_en`/`fifo_data_in` connect to the FIFO's `wr_en`/`data_in`, and its `fifo_full` input connects to the FIFO's `full`.

## Interface
- NUM_REQ, 4: number of producers, 2..16.
- DATA_W, 8: data width; matches FIFO `data_in`.
- BURST_MAX, 4: maximum accepted beats per grant, ≥1.
- CNT_W, 16: statistics counter width.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  producer i has a beat.
- req_data  in  NUM_REQ*DATA_W  producer i data in slice [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  beat i accepted this cycle when valid&ready.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_data_in  out  DATA_W  FIFO write data.
- grant_valid  out  1  a producer currently owns the port.
- grant_id  out  $clog2(NUM_REQ)  current owner index.
- grant_cnt  out  NUM_REQ*CNT_W  per-producer accepted-beat counters (see Configuration).
- stall_cnt  out  CNT_W  cycles owned but blocked by full (see Configuration).

## Operation
- Two states, encoded in package type `arb_state_t`:
  - IDLE: no owner.
  - BURST: owner = `grant_id`.
- Registered state: `state`, `grant_id`, `rr_ptr` (next-priority index), and `beat_cnt` ($clog2(BURST_MAX+1) bits).
- IDLE:
  - All `req_ready`=0 and `fifo_wr_en`=0.
  - If any `req_valid`, pick the first valid index searching `rr_ptr`, `rr_ptr`+1, … modulo NUM_REQ.
  - Next edge: state=BURST, `grant_id`=pick, `beat_cnt`=0.
- BURST, with owner c:
  - `req_ready[c]` = !`fifo_full`; all other `req_ready`=0.
  - `fifo_wr_en` = `req_valid[c]` & !`fifo_full`.
  - `fifo_data_in` = `req_data` slice c (combinational mux); when not writing, it holds slice c.
  - Each accepted beat increments `beat_cnt`.
- Release, on the edge where either condition holds:
  - (a) an accepted beat makes `beat_cnt` reach BURST_MAX, or
  - (b) `req_valid[c]`=0.
  - On release: state=IDLE, `rr_ptr`=(c+1) mod NUM_REQ.
- Full stall: while `fifo_full`=1 with `req_valid[c]`=1, the owner keeps the grant, no beat is counted, and there is no timeout.
- A producer must hold `req_valid`/`req_data` stable until accepted.
- Combinational paths from `fifo_full` to `fifo_wr_en`/`req_ready` are intentional. The FIFO therefore never sees `wr_en`=1 while `full`=1.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0, `grant_valid`=0, `fifo_wr_en`=0, `fifo_data_in`=0, all `req_ready`=0, counters=0.
- Reset mid-burst aborts the burst immediately. The beat on the reset edge is not accepted.
- Latency: `req_valid` rising in IDLE → first acceptance 1 cycle later (the cycle after the grant edge).
- Throughput: BURST_MAX beats per BURST_MAX+1 cycles; one IDLE arbitration cycle follows every release.
- Simultaneous requests resolve strictly by `rr_ptr` rotation; the released owner has lowest priority at the next arbitration.
- NUM_REQ not a power of two: `rr_ptr` and pick wrap explicitly at NUM_REQ-1.

## Configuration
- Macro `FIFO_ARB_STATS_EN`.
- Defined:
  - `grant_cnt[i]` increments on each accepted beat of producer i.
  - `stall_cnt` increments each BURST cycle with `req_valid[c]`&`fifo_full`.
  - All counters saturate at 2^CNT_W-1 and clear only on reset.
- Undefined: counter logic is absent, and the `grant_cnt`/`stall_cnt` ports remain but are tied to 0.

## Structure
- Package `fifo_arb_pkg` contains:
  - `arb_state_t` enum (IDLE, BURST).
  - Default constants for NUM_REQ, DATA_W, BURST_MAX, CNT_W.
- Sub-module `rr_pick`: combinational round-robin priority search.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: `pick_valid`, `pick_idx`.
  - Instantiated once.

## Test plan
Defaults NUM_REQ=4, DATA_W=8, BURST_MAX=4 throughout.
- Single producer: `req_valid[2]`=1 streaming 56,7,41,5,12,6 with FIFO never full.
  - → Grant to 2 one cycle after valid; beats 56,7,41,5 written on consecutive cycles, then 1 IDLE cycle.
  - → 12,6 written on the regrant; `grant_cnt[2]`=6.
- All four valid continuously from reset → grant order 0,1,2,3,0…; each grant writes exactly 4 beats; `rr_ptr` wraps 3→0.
- `fifo_full`=1 for 5 cycles mid-burst of owner 1 after 2 beats:
  - → `fifo_wr_en`=0 and `req_ready[1]`=0 during the stall; `stall_cnt`=5.
  - → Owner kept; exactly 2 more beats after full drops.
- Owner 0 drops `req_valid` after 1 beat while 3 is valid → release; next grant 3; `beat_cnt` restarts at 0.
- `rst_n` asserted mid-burst → same cycle: `fifo_wr_en`=0, `grant_valid`=0, counters=0; after deassert, arbitration restarts from index 0.
- Build without `FIFO_ARB_STATS_EN` → `grant_cnt`=0 and `stall_cnt`=0 under the all-four-valid stimulus; write sequence identical to the build with stats.
